// File: rtl/sprite_pkg.sv
// Shared types, screen limits and ROM helpers for the sprite renderer.
// rom_pattern defines the built-in sprite image the ROM is filled with.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic int rom_depth(input int frames, input int w, input int h);
    return frames * w * h;
  endfunction

  // Frame f, texel t -> ((t mod M) + 1 + M*f) mod (M+1), M = 2**idx_w - 1.
  // Frame 0 is fully opaque; later frames shift which texels hit index 0.
  function automatic int rom_pattern(input int addr, input int texels, input int idx_w);
    int m;
    m = (1 << idx_w) - 1;
    return ((addr % texels) % m + 1 + m * (addr / texels)) % (m + 1);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous-read sprite ROM holding all animation frames back to back.
// Contents come from sprite_pkg::rom_pattern; q is valid one cycle after addr.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 3,
  parameter int TEXELS = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              vga_clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  q
);

  logic [IDX_W-1:0] mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_init
      assign mem[gi] = IDX_W'(rom_pattern(gi, TEXELS, IDX_W));
    end
  endgenerate

  always_ff @(posedge vga_clk) begin
    q <= mem[addr];
  end

endmodule

// File: rtl/sprite_renderer.sv
// Draws one scaled, animated, palette-indexed sprite over a background stream.
// Two-cycle pipeline: window/address, ROM read, palette + composite.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int SCALE_LOG2 = 1,
  parameter int FRAMES     = 4,
  parameter int IDX_W      = 3,
  parameter int TRANSP_IDX = 0,
  parameter int FRAME_DIV  = 8
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       frame_start,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       pos_wr,
  input  logic       anim_en,
  input  logic [3:0] bg_red,
  input  logic [3:0] bg_green,
  input  logic [3:0] bg_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hit
);

  localparam int TEXELS  = SPR_W * SPR_H;
  localparam int DEPTH   = rom_depth(FRAMES, SPR_W, SPR_H);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int WIN_W   = SPR_W << SCALE_LOG2;
  localparam int WIN_H   = SPR_H << SCALE_LOG2;

  logic [9:0]         pend_x_reg, pend_y_reg, act_x_reg, act_y_reg;
  logic [CNT_W-1:0]   anim_cnt_reg;
  logic [FRAME_W-1:0] frame_idx_reg;

  // A write coinciding with frame_start bypasses pending straight to active.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pend_x_reg <= '0;
      pend_y_reg <= '0;
      act_x_reg  <= '0;
      act_y_reg  <= '0;
    end else begin
      if (pos_wr) begin
        pend_x_reg <= pos_x;
        pend_y_reg <= pos_y;
      end
      if (frame_start) begin
        act_x_reg <= pos_wr ? pos_x : pend_x_reg;
        act_y_reg <= pos_wr ? pos_y : pend_y_reg;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      anim_cnt_reg  <= '0;
      frame_idx_reg <= '0;
    end else if (frame_start && anim_en) begin
      if (anim_cnt_reg == CNT_W'(FRAME_DIV - 1)) begin
        anim_cnt_reg  <= '0;
        frame_idx_reg <= (frame_idx_reg == FRAME_W'(FRAMES - 1)) ? '0 : frame_idx_reg + 1'b1;
      end else begin
        anim_cnt_reg <= anim_cnt_reg + 1'b1;
      end
    end
  end

  // S0: window test in 11 bits so positions near the right/bottom edge clip, never wrap.
  logic [10:0]       dx, dy, tx, ty;
  logic              in_win;
  logic [ADDR_W-1:0] rom_addr;

  assign dx = {1'b0, DrawX} - {1'b0, act_x_reg};
  assign dy = {1'b0, DrawY} - {1'b0, act_y_reg};
  assign tx = dx >> SCALE_LOG2;
  assign ty = dy >> SCALE_LOG2;
  assign in_win = (DrawX >= act_x_reg) && (DrawY >= act_y_reg) &&
                  (dx < 11'(WIN_W)) && (dy < 11'(WIN_H)) &&
                  (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
  assign rom_addr = ADDR_W'(int'(frame_idx_reg) * TEXELS + int'(ty) * SPR_W + int'(tx));

  logic [IDX_W-1:0] texel_idx;

  sprite_rom #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .TEXELS (TEXELS),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .vga_clk (vga_clk),
    .addr    (rom_addr),
    .q       (texel_idx)
  );

  // S1: side-band delayed to line up with the ROM output.
  logic    blank_d1_reg, win_d1_reg;
  rgb444_t bg_d1_reg;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_d1_reg <= 1'b0;
      win_d1_reg   <= 1'b0;
      bg_d1_reg    <= '0;
    end else begin
      blank_d1_reg <= blank;
      win_d1_reg   <= in_win;
      bg_d1_reg    <= '{r: bg_red, g: bg_green, b: bg_blue};
    end
  end

  rgb444_t pal_tbl [2**IDX_W];

  generate
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_pal
      assign pal_tbl[gi] = '{r: 4'(gi), g: 4'(gi * 3), b: 4'(15 - gi)};
    end
  endgenerate

  // S2: composite and register the outputs.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      {red, green, blue} <= '0;
      hit                <= 1'b0;
    end else if (!blank_d1_reg) begin
      {red, green, blue} <= '0;
      hit                <= 1'b0;
    end else if (win_d1_reg && (texel_idx != IDX_W'(TRANSP_IDX))) begin
      {red, green, blue} <= pal_tbl[texel_idx];
      hit                <= 1'b1;
    end else begin
      {red, green, blue} <= bg_d1_reg;
      hit                <= 1'b0;
    end
  end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
Parametrised successor to the full-screen scaled-ROM image drawer. It draws one palette-indexed, multi-frame animated sprite at a runtime-programmable position with an integer power-of-two scale factor. A transparency index lets the sprite composite over a background pixel stream. Position updates are double-buffered to frame boundaries. It sits between the VGA controller (DrawX/DrawY/blank) and the colour mapper, one instance per sprite.

Parameters:
SPR_W, 32, sprite width in source pixels (power of two)
SPR_H, 32, sprite height in source pixels (power of two)
SCALE_LOG2, 1, on-screen scale = 2**SCALE_LOG2 in each axis
FRAMES, 4, number of animation frames stored back-to-back in ROM (power of two)
IDX_W, 3, palette index width
TRANSP_IDX, 0, palette index treated as transparent
FRAME_DIV, 8, screen frames per animation step (>=1)

Ports:
vga_clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video region (same cycle as DrawX/DrawY)
frame_start  in  1  one-cycle pulse at start of vertical blanking
pos_x  in  10  requested sprite left edge
pos_y  in  10  requested sprite top edge
pos_wr  in  1  latch pos_x/pos_y into pending registers
anim_en  in  1  1 = animation advances
bg_red, bg_green, bg_blue  in  4 each  background colour for (DrawX, DrawY)
red, green, blue  out  4 each  composited colour
hit  out  1  1 = sprite pixel at this output position is opaque

Behaviour:
- Reset (async, any time): active/pending pos = 0, anim counter = 0, frame index = 0, pipeline valid bits cleared, red/green/blue = 0, hit = 0.
- Pipeline: fixed latency 2 cycles from DrawX/DrawY/blank/bg_* to red/green/blue/hit.
  - S0 (comb): window test and address.
  - ROM read registered (S1).
  - Palette lookup and mux, registered (S2 = outputs).
  - blank, bg_*, and in-window flag are delayed internally to align.
- Window: dx = DrawX - act_x, dy = DrawY - act_y, computed in 11 bits. In-window when DrawX >= act_x, DrawY >= act_y, dx < SPR_W<<SCALE_LOG2, and dy < SPR_H<<SCALE_LOG2.
  - A sprite partially past column 639 / row 479 is clipped naturally. No wrap to the left or top edge.
- Address: frame_idx*SPR_W*SPR_H + (dy>>SCALE_LOG2)*SPR_W + (dx>>SCALE_LOG2). ROM depth = FRAMES*SPR_W*SPR_H.
- Output at S2:
  - blank_d = 0: outputs 0, hit = 0.
  - Else, in-window and index != TRANSP_IDX: palette colour, hit = 1.
  - Else: bg colour, hit = 0.
- Position double-buffer:
  - pos_wr loads pending.
  - frame_start copies pending to active.
  - pos_wr and frame_start in the same cycle: the new pos_x/pos_y go directly to both pending and active.
  - Active position never changes outside a frame_start cycle.
- Animation: on frame_start with anim_en = 1:
  - anim counter increments.
  - When the counter = FRAME_DIV-1, it clears and frame_idx advances mod FRAMES (wraps FRAMES-1 -> 0).
  - anim_en = 0 freezes both counter and frame_idx; there is no clear.
  - frame_idx changes only on frame_start, so there is no tearing.
- No combinational path from any input to any output.

Decomposition:
- Package sprite_pkg: IDX_W-agnostic rgb444 struct type; SCREEN_W = 640, SCREEN_H = 480 constants; helper function for ROM depth.
- One natural sub-module: sprite_rom, a synchronous-read ROM, parametrised by depth/IDX_W/init file, with a 1-cycle q.
- Palette stays a combinational lookup instanced alongside it.

Test Plan:
1. Reset: assert reset mid-line with anim running -> outputs immediately 0, hit 0; after release, frame_idx 0 and active pos (0,0).
2. Placement and scale: pos_wr (100,50) then frame_start.
   - DrawX = 100, DrawY = 50 -> 2 cycles later hit = 1 with ROM[0]'s colour.
   - DrawX = 101 -> same texel.
   - DrawX = 163 -> texel 31.
   - DrawX = 164 -> bg colour, hit = 0.
3. Transparency: ROM texel = TRANSP_IDX at window origin, bg = 0xA,0x5,0x3 -> output A/5/3, hit = 0. blank = 0 at the same point -> output 0.
4. Double-buffer: pos_wr (200,200) mid-frame -> remaining lines still draw at (100,50); after frame_start draws at (200,200). Simultaneous pos_wr (300,10) with frame_start -> next frame at (300,10).
5. Animation: anim_en = 1, FRAME_DIV = 8 -> frame_idx steps 0,1,2,3,0 every 8 frame_start pulses. anim_en = 0 after 3 pulses then 10 pulses -> frame_idx unchanged, and resumes counting from 3.
6. Clipping: pos (620,470) -> pixels at DrawX 620..639 and DrawY 470..479 drawn; nothing appears at column 0 or row 0.
